// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the systolic array drain path.
package systolic_pkg;
  localparam int DATA_W_DEFAULT = 16;
  typedef struct packed {
    logic                      last;
    logic [DATA_W_DEFAULT-1:0] col1;
    logic [DATA_W_DEFAULT-1:0] col0;
  } drain_row_t;
  // Keep-mask bit for ReLU: a value survives only when its sign bit is clear.
  function automatic logic relu(input logic msb);
    return !msb;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-file FIFO with occupancy count; head is shown combinationally from storage.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
  always_comb begin
    empty   = level == '0;
    full    = level == LW'(DEPTH);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level  <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: de-skews the two array columns into rows, tags tile-last rows, buffers them.
// Define SYSTOLIC_DRAIN_RELU_EN to zero negative column values as they are stored.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int ROWS   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      col0_in,
  input  logic [DATA_W-1:0]      col1_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_col0,
  output logic [DATA_W-1:0]      out_col1,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear,
  output logic                   busy
);
  localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
  logic              skew_v, full, empty, pop, last;
  logic [DATA_W-1:0] col0_d, c0, c1;
  logic [CW-1:0]     row_cnt, cnt_eff;
  logic [2*DATA_W:0] row_in, row_out;
  // clear takes effect for a push in the same cycle, so the count used is the cleared one.
  always_comb begin
    cnt_eff = clear ? '0 : row_cnt;
    last    = cnt_eff == LAST_ROW;
`ifdef SYSTOLIC_DRAIN_RELU_EN
    c0 = col0_d & {DATA_W{relu(col0_d[DATA_W-1])}};
    c1 = col1_in & {DATA_W{relu(col1_in[DATA_W-1])}};
`else
    c0 = col0_d;
    c1 = col1_in;
`endif
    row_in    = {last, c1, c0};
    out_valid = ~empty;
    pop       = out_valid & out_ready;
    {out_last, out_col1, out_col0} = row_out;
    busy      = skew_v | ~empty;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      skew_v   <= 1'b0;
      col0_d   <= '0;
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      skew_v   <= in_valid;
      if (in_valid) col0_d <= col0_in;
      row_cnt  <= skew_v ? (last ? '0 : cnt_eff + 1'b1) : cnt_eff;
      overflow <= clear ? 1'b0 : overflow | (skew_v & full & ~pop);
    end
  sync_fifo #(.W(2*DATA_W+1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (skew_v),
    .pop   (pop),
    .din   (row_in),
    .dout  (row_out),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed stimulus with a queue scoreboard for systolic_drain.
module tb_systolic_drain;
  import systolic_pkg::*;
  logic        clk = 0, rst = 0, in_valid = 0, out_ready = 0, clear = 0;
  logic [15:0] col0_in = 0, col1_in = 0;
  logic        out_valid, out_last, overflow, busy;
  logic [15:0] out_col0, out_col1;
  logic [2:0]  level;
  int checks = 0, errors = 0;
  drain_row_t  q[$];
  logic        m_skew = 0, exp_ovf = 0;
  logic [15:0] m_c0 = 0;
  int          m_cnt = 0;

  systolic_drain dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .col0_in(col0_in), .col1_in(col1_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_col0(out_col0), .out_col1(out_col1),
    .out_last(out_last), .level(level), .overflow(overflow), .clear(clear), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] relu_m(input logic [15:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    return v[15] ? 16'h0 : v;
`else
    return v;
`endif
  endfunction

  // One clock: compare at the falling edge, advance the model, then step past the rising edge.
  task automatic cyc();
    drain_row_t r;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("overflow", overflow, exp_ovf);
    chk("busy", busy, m_skew || q.size() != 0);
    if (q.size() != 0 && out_ready) begin
      r = q.pop_front();
      chk("out_col0", out_col0, r.col0);
      chk("out_col1", out_col1, r.col1);
      chk("out_last", out_last, r.last);
    end
    if (clear) m_cnt = 0;
    if (m_skew) begin
      r.col0 = relu_m(m_c0);
      r.col1 = relu_m(col1_in);
      r.last = m_cnt == 1;
      if (q.size() < 4) q.push_back(r); else exp_ovf = 1;
      m_cnt = (m_cnt + 1) % 2;
    end
    if (clear) exp_ovf = 0;
    m_skew = in_valid;
    if (in_valid) m_c0 = col0_in;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rows(input int n, input logic [15:0] base, input logic rdy);
    for (int i = 0; i <= n; i++) begin
      in_valid = i < n;
      col0_in  = 16'(base + 16'(i));
      col1_in  = 16'(base + 16'h100 + 16'(i) - 16'h1);
      if (i == 1) out_ready = rdy;
      cyc();
    end
    in_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_col0", out_col0, 0);
    chk("rst_col1", out_col1, 0);
    chk("rst_last", out_last, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    // single row latency
    in_valid = 1; col0_in = 16'h0003;
    cyc();
    in_valid = 0; col1_in = 16'h0005;
    cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_col0", out_col0, 16'h0003);
    chk("t1_col1", out_col1, 16'h0005);
    chk("t1_last", out_last, 0);
    out_ready = 1;
    cyc();
    // tile framing from a fresh row count
    clear = 1;
    cyc();
    clear = 0;
    send_rows(4, 16'h0010, 1);
    repeat (3) cyc();
    // overflow and recovery
    out_ready = 0;
    send_rows(5, 16'h0020, 0);
    cyc();
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    out_ready = 1;
    repeat (5) cyc();
    chk("drain_level", level, 0);
    clear = 1;
    cyc();
    clear = 0;
    chk("clear_ovf", overflow, 0);
    send_rows(2, 16'h0030, 1);
    repeat (3) cyc();
    // full with simultaneous push and pop
    out_ready = 0;
    send_rows(4, 16'h0040, 0);
    cyc();
    chk("full_level", level, 4);
    send_rows(4, 16'h0050, 1);
    chk("fullpp_level", level, 4);
    chk("fullpp_ovf", overflow, 0);
    repeat (5) cyc();
    // reset mid-stream with rows queued and skew stage loaded
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; col0_in = 16'(16'h0060 + 16'(i)); col1_in = 16'(16'h0160 + 16'(i));
      cyc();
    end
    in_valid = 0;
    chk("pre_rst_level", level, 3);
    #2 rst = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_col0", out_col0, 0);
    q.delete(); m_skew = 0; m_cnt = 0; exp_ovf = 0;
    @(posedge clk);
    #1;
    rst = 1; col1_in = 16'h0077;
    cyc();
    cyc();
    chk("late_col1_level", level, 0);
    // sign handling
    in_valid = 1; col0_in = 16'hFFFE;
    cyc();
    in_valid = 0; col1_in = 16'h0007;
    cyc();
`ifdef SYSTOLIC_DRAIN_RELU_EN
    chk("relu_col0", out_col0, 16'h0000);
`else
    chk("relu_col0", out_col0, 16'hFFFE);
`endif
    chk("relu_col1", out_col1, 16'h0007);
    out_ready = 1;
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
